// File: rtl/int_status_readout.sv
// Interrupt status readout: edge-latched pending register with inhibit mask,
// masked clear, and an MSB-first serial snapshot of the pending word.
module int_status_readout #(
    parameter int NINT  = 12,
    parameter int WIDTH = 26
) (
    input  logic            SIM_CLK,
    input  logic            SIM_RST,
    input  logic            BIT_STB,
    input  logic            RD_REQ,
    input  logic            CLR_STB,
    input  logic [NINT-1:0] CLR_MASK,
    input  logic [NINT-1:0] INT_SRC,
    input  logic [NINT-1:0] INH,
    output logic [NINT-1:0] PEND,
    output logic            INT_OUT,
    output logic            SER_DOUT,
    output logic            SER_VALID,
    output logic            BUSY,
    output logic            DONE
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARM     = 2'd1;
    localparam logic [1:0] SHIFT   = 2'd2;
    localparam logic [1:0] DONE_ST = 2'd3;

    logic [1:0]       state_reg;
    logic [NINT-1:0]  hist_reg;
    logic [NINT-1:0]  pend_reg;
    logic [NINT-1:0]  pend_next;
    logic [NINT-1:0]  rise;
    logic             int_out_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] snap_word;
    logic [CW-1:0]    cnt_reg;
    logic             ser_dout_reg;
    logic             ser_valid_reg;
    logic             busy_reg;
    logic             done_reg;

    // Set dominates clear: an edge arriving with its clear still latches.
    generate
        for (genvar gi = 0; gi < NINT; gi++) begin : g_pend
            assign rise[gi]      = INT_SRC[gi] & ~hist_reg[gi];
            assign pend_next[gi] = (pend_reg[gi] & ~(CLR_STB & CLR_MASK[gi]))
                                 | (rise[gi] & ~INH[gi]);
        end
    endgenerate

    always_comb begin
        snap_word                  = '0;
        snap_word[WIDTH-1 -: NINT] = pend_reg;
        shift_next                 = shift_reg << 1;
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_reg     <= IDLE;
            hist_reg      <= INT_SRC;
            pend_reg      <= '0;
            int_out_reg   <= 1'b0;
            shift_reg     <= '0;
            cnt_reg       <= '0;
            ser_dout_reg  <= 1'b0;
            ser_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            hist_reg    <= INT_SRC;
            pend_reg    <= pend_next;
            int_out_reg <= |pend_reg;
            done_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (RD_REQ) begin
                        shift_reg <= snap_word;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ARM;
                    end
                end
                ARM: begin
                    if (BIT_STB) begin
                        ser_dout_reg  <= shift_reg[WIDTH-1];
                        ser_valid_reg <= 1'b1;
                        cnt_reg       <= CW'(1);
                        state_reg     <= SHIFT;
                    end
                end
                SHIFT: begin
                    // cnt_reg holds the number of bits already presented.
                    if (BIT_STB) begin
                        if (cnt_reg == CW'(WIDTH)) begin
                            ser_dout_reg  <= 1'b0;
                            ser_valid_reg <= 1'b0;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                            state_reg     <= DONE_ST;
                        end else begin
                            shift_reg    <= shift_next;
                            ser_dout_reg <= shift_next[WIDTH-1];
                            cnt_reg      <= cnt_reg + CW'(1);
                        end
                    end
                end
                DONE_ST: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign PEND      = pend_reg;
    assign INT_OUT   = int_out_reg;
    assign SER_DOUT  = ser_dout_reg;
    assign SER_VALID = ser_valid_reg;
    assign BUSY      = busy_reg;
    assign DONE      = done_reg;

endmodule
